// File: rtl/core_bpu.sv
// Fetch-side branch predictor: BTB, local history, 2-bit PHT, return-address stack when BPU_RAS_EN is defined.
// Latency: 1 cycle from accepted fetch to bpu_predict_o; corrections update state on the next edge.
// Backpressure: fetch_stall_i holds predict_valid_o/bpu_predict_o; no fetch is accepted until the init sweep ends.
package core_bpu_pkg;
   localparam int BPU_HIST_W    = 6;
   localparam int BPU_RAS_PTR_W = 3;

   typedef struct packed {
      logic [31:0]              predict_pc;
      logic                     taken;
      logic [1:0]               lphr;
      logic [BPU_HIST_W-1:0]    history;
      logic                     dir_type;
      logic [1:0]               target_type;
      logic [BPU_RAS_PTR_W-1:0] ras_ptr;
   } bpu_predict_t;

   typedef struct packed {
      logic                     miss;
      logic [31:0]              pc;
      logic                     true_taken;
      logic [31:0]              true_target;
      logic                     true_dir;
      logic [1:0]               true_target_type;
      logic [BPU_HIST_W-1:0]    history;
      logic [1:0]               lphr;
      logic [BPU_RAS_PTR_W-1:0] ras_ptr;
   } bpu_correct_t;
endpackage

module core_bpu
   import core_bpu_pkg::*;
#(
   parameter int ENTRIES   = 64,
   parameter int TAG_W     = 16,
   parameter int HIST_W    = BPU_HIST_W,
   parameter int RAS_DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   output logic         ready_o,
   input  logic         fetch_valid_i,
   input  logic         fetch_stall_i,
   input  logic [31:0]  fetch_pc_i,
   output logic         predict_valid_o,
   output bpu_predict_t bpu_predict_o,
   input  logic         correct_valid_i,
   input  bpu_correct_t bpu_correct_i
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int PHT_N = 1 << HIST_W;
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] init_idx;
   logic [HIST_W-1:0] init_pht;

   logic             btb_vld  [ENTRIES];
   logic [TAG_W-1:0] btb_tag  [ENTRIES];
   logic [31:0]      btb_tgt  [ENTRIES];
   logic             btb_dir  [ENTRIES];
   logic [1:0]       btb_type [ENTRIES];
   logic [HIST_W-1:0] lhr     [ENTRIES];
   logic [1:0]       pht      [PHT_N];

   logic             accept;
   logic [IDX_W-1:0] f_idx, c_idx;
   logic             f_hit, f_taken;
   logic [HIST_W-1:0] f_hist;
   logic [1:0]       f_lphr, c_lphr_new;
   logic [31:0]      f_target;
   logic [PTR_W-1:0] ras_ptr;
   logic [31:0]      ras_top;
   bpu_predict_t     pred_next;

   assign ready_o  = (state == ST_RUN);
   assign accept   = fetch_valid_i & ~fetch_stall_i & ready_o;
   assign init_pht = HIST_W'(init_idx);

   assign f_idx  = fetch_pc_i[IDX_W+1:2];
   assign f_hit  = btb_vld[f_idx] && (btb_tag[f_idx] == fetch_pc_i[IDX_W+2 +: TAG_W]);
   assign f_hist = lhr[f_idx];
   assign f_lphr = pht[f_hist];
   assign c_idx  = bpu_correct_i.pc[IDX_W+1:2];

`ifdef BPU_RAS_EN
   localparam bit RAS_EN = 1'b1;
   logic [31:0]      ras [RAS_DEPTH];
   logic [PTR_W-1:0] c_rp;

   assign c_rp    = bpu_correct_i.ras_ptr;
   assign ras_top = ras[ras_ptr - PTR_W'(1)];

   // A mispredict repair owns the stack; that cycle's speculative push/pop is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         ras_ptr <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
      end else if (correct_valid_i && ready_o && bpu_correct_i.miss) begin
         ras_ptr <= c_rp;
         case (bpu_correct_i.true_target_type)
            2'd1: begin
               ras[c_rp] <= bpu_correct_i.pc + 32'd4;
               ras_ptr   <= c_rp + PTR_W'(1);
            end
            2'd2:    ras_ptr <= c_rp - PTR_W'(1);
            default: ;
         endcase
      end else if (accept && f_hit && f_taken) begin
         case (btb_type[f_idx])
            2'd1: begin
               ras[ras_ptr] <= fetch_pc_i + 32'd4;
               ras_ptr      <= ras_ptr + PTR_W'(1);
            end
            2'd2:    ras_ptr <= ras_ptr - PTR_W'(1);
            default: ;
         endcase
      end
   end
`else
   localparam bit RAS_EN = 1'b0;
   logic unused_ras;
   assign ras_ptr    = '0;
   assign ras_top    = '0;
   assign unused_ras = ^{bpu_correct_i.miss, bpu_correct_i.pc, bpu_correct_i.ras_ptr};
`endif

   assign f_taken  = btb_dir[f_idx] ? f_lphr[1] : 1'b1;
   assign f_target = (RAS_EN && btb_type[f_idx] == 2'd2) ? ras_top : btb_tgt[f_idx];

   always_comb begin
      pred_next            = '0;
      pred_next.history    = f_hist;
      pred_next.lphr       = f_lphr;
      pred_next.ras_ptr    = ras_ptr;
      pred_next.predict_pc = fetch_pc_i + 32'd4;
      if (f_hit) begin
         pred_next.dir_type    = btb_dir[f_idx];
         pred_next.target_type = btb_type[f_idx];
         pred_next.taken       = f_taken;
         if (f_taken) pred_next.predict_pc = f_target;
      end
   end

   always_comb begin
      c_lphr_new = bpu_correct_i.lphr;
      if (bpu_correct_i.true_taken) begin
         if (bpu_correct_i.lphr != 2'b11) c_lphr_new = bpu_correct_i.lphr + 2'b01;
      end else if (bpu_correct_i.lphr != 2'b00) begin
         c_lphr_new = bpu_correct_i.lphr - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_INIT;
         init_idx        <= '0;
         predict_valid_o <= 1'b0;
         bpu_predict_o   <= '0;
      end else begin
         if (state == ST_INIT) begin
            init_idx <= init_idx + IDX_W'(1);
            if (init_idx == IDX_W'(ENTRIES - 1)) state <= ST_RUN;
         end
         if (!fetch_stall_i) begin
            predict_valid_o <= accept;
            if (accept) bpu_predict_o <= pred_next;
         end
      end
   end

   // Storage has no reset; the init sweep clears it. Lookups above see pre-edge contents.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_INIT) begin
            btb_vld[init_idx] <= 1'b0;
            lhr[init_idx]     <= '0;
            pht[init_pht]     <= 2'b01;
         end else if (correct_valid_i) begin
            if (bpu_correct_i.true_taken) begin
               btb_vld[c_idx]  <= 1'b1;
               btb_tag[c_idx]  <= bpu_correct_i.pc[IDX_W+2 +: TAG_W];
               btb_tgt[c_idx]  <= bpu_correct_i.true_target;
               btb_dir[c_idx]  <= bpu_correct_i.true_dir;
               btb_type[c_idx] <= bpu_correct_i.true_target_type;
            end
            if (bpu_correct_i.true_dir)
               lhr[c_idx] <= {bpu_correct_i.history[HIST_W-2:0], bpu_correct_i.true_taken};
            pht[bpu_correct_i.history] <= c_lphr_new;
         end
      end
   end
endmodule

// File: tb/tb_core_bpu.sv
// Bench for core_bpu: directed vector table, init/reset sequences, then random traffic against a reference model.
module tb_core_bpu;
   import core_bpu_pkg::*;

`ifdef BPU_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif
   localparam logic [31:0] C = 32'h1C00_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic         ready_o;
   logic         fetch_valid_i, fetch_stall_i;
   logic [31:0]  fetch_pc_i;
   logic         predict_valid_o;
   bpu_predict_t bpu_predict_o;
   logic         correct_valid_i;
   bpu_correct_t bpu_correct_i;

   core_bpu dut (
      .clk(clk), .rst(rst), .ready_o(ready_o),
      .fetch_valid_i(fetch_valid_i), .fetch_stall_i(fetch_stall_i), .fetch_pc_i(fetch_pc_i),
      .predict_valid_o(predict_valid_o), .bpu_predict_o(bpu_predict_o),
      .correct_valid_i(correct_valid_i), .bpu_correct_i(bpu_correct_i)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bpu_correct_t mk(input logic miss, input logic [31:0] pc, input logic tk,
                                       input logic [31:0] tgt, input logic dir, input logic [1:0] tt,
                                       input logic [5:0] h, input logic [1:0] lp, input logic [2:0] rp);
      bpu_correct_t c;
      c = '0;
      c.miss = miss; c.pc = pc; c.true_taken = tk; c.true_target = tgt;
      c.true_dir = dir; c.true_target_type = tt; c.history = h; c.lphr = lp; c.ras_ptr = rp;
      return c;
   endfunction

   typedef struct {
      bit           dc;
      bpu_correct_t c;
      bit           df;
      logic [31:0]  pc;
      bit           et;
      logic [31:0]  epc;
      logic [1:0]   ett;
      logic [2:0]   eras;
      bit           cl;
      logic [1:0]   el;
   } vec_t;
   vec_t vt[40];
   int   nv = 0;

   task automatic add(input bit dc, input bpu_correct_t c, input bit df, input logic [31:0] pc,
                      input bit et, input logic [31:0] epc, input logic [1:0] ett,
                      input logic [2:0] eras, input bit cl, input logic [1:0] el);
      vt[nv] = '{dc, c, df, pc, et, epc, ett, eras, cl, el};
      nv++;
   endtask

   // Reference model: plain arrays indexed by pc word bits, stack as modulo-8 array.
   bit          m_v   [64];
   int          m_tag [64];
   logic [31:0] m_tgt [64];
   bit          m_dir [64];
   int          m_tt  [64];
   int          m_lhr [64];
   int          m_pht [64];
   logic [31:0] m_ras [8];
   int          m_ptr;

   function automatic bpu_predict_t m_predict(input logic [31:0] pc);
      bpu_predict_t p;
      int idx, h;
      idx = int'(pc[7:2]);
      h   = m_lhr[idx];
      p = '0;
      p.history    = 6'(h);
      p.lphr       = 2'(m_pht[h]);
      p.ras_ptr    = RAS_EN ? 3'(m_ptr) : 3'd0;
      p.predict_pc = pc + 4;
      if (m_v[idx] && m_tag[idx] == int'(pc[23:8])) begin
         p.dir_type    = m_dir[idx];
         p.target_type = 2'(m_tt[idx]);
         p.taken       = m_dir[idx] ? (m_pht[h] >= 2) : 1'b1;
         if (p.taken)
            p.predict_pc = (RAS_EN && m_tt[idx] == 2) ? m_ras[(m_ptr + 7) % 8] : m_tgt[idx];
      end
      return p;
   endfunction

   task automatic m_step(input bit cv, input bpu_correct_t c, input bit acc, input bpu_predict_t p,
                         input logic [31:0] pc);
      int idx, l, rp;
      if (cv) begin
         idx = int'(c.pc[7:2]);
         if (c.true_taken) begin
            m_v[idx] = 1'b1; m_tag[idx] = int'(c.pc[23:8]); m_tgt[idx] = c.true_target;
            m_dir[idx] = c.true_dir; m_tt[idx] = int'(c.true_target_type);
         end
         if (c.true_dir) m_lhr[idx] = (int'(c.history) * 2 + int'(c.true_taken)) % 64;
         l = int'(c.lphr);
         m_pht[int'(c.history)] = c.true_taken ? ((l == 3) ? 3 : l + 1) : ((l == 0) ? 0 : l - 1);
      end
      if (RAS_EN) begin
         if (cv && c.miss) begin
            rp = int'(c.ras_ptr);
            if (c.true_target_type == 2'd1) begin
               m_ras[rp] = c.pc + 4; m_ptr = (rp + 1) % 8;
            end else if (c.true_target_type == 2'd2) m_ptr = (rp + 7) % 8;
            else m_ptr = rp;
         end else if (acc && p.taken) begin
            if (p.target_type == 2'd1) begin
               m_ras[m_ptr] = pc + 4; m_ptr = (m_ptr + 1) % 8;
            end else if (p.target_type == 2'd2) m_ptr = (m_ptr + 7) % 8;
         end
      end
   endtask

   task automatic fetch_chk(input string nm, input logic [31:0] pc, input bit et, input logic [31:0] epc);
      fetch_valid_i = 1'b1; fetch_pc_i = pc;
      @(negedge clk);
      fetch_valid_i = 1'b0;
      check({nm, ".valid"}, predict_valid_o, 1'b1);
      check({nm, ".taken"}, bpu_predict_o.taken, et);
      check({nm, ".pc"}, bpu_predict_o.predict_pc, epc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int n, bad;
      bit fv, st, cv, acc;
      logic [31:0] pc;
      bpu_correct_t c;
      bpu_predict_t p, exp_pred;
      bit exp_valid;

      rst = 1'b1; fetch_valid_i = 1'b0; fetch_stall_i = 1'b0; fetch_pc_i = '0;
      correct_valid_i = 1'b0; bpu_correct_i = '0;

      // Directed vectors: {correction, fetch, expected prediction}
      add(0, '0, 1, C, 0, C + 32'h4, 0, 0, 1, 2'b01);
      add(1, mk(0, C + 32'h100, 1, C + 32'h800, 0, 3, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, '0, 1, C + 32'h100, 1, C + 32'h800, 3, 0, 0, 0);
      add(1, mk(0, C + 32'h40, 1, C + 32'h480, 1, 0, 63, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, mk(0, C + 32'h40, 1, C + 32'h480, 1, 0, 63, 2, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, '0, 1, C + 32'h40, 1, C + 32'h480, 0, 0, 1, 2'b11);
      add(1, mk(0, C + 32'h40, 0, C + 32'h480, 1, 0, 63, 3, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, mk(0, C + 32'h40, 1, C + 32'h480, 1, 0, 31, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, '0, 1, C + 32'h40, 1, C + 32'h480, 0, 0, 1, 2'b10);
      add(1, mk(0, C + 32'h200, 1, C + 32'h1000, 0, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, mk(0, C + 32'h1010, 1, C + 32'h3000, 0, 2, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, '0, 1, C + 32'h200, 1, C + 32'h1000, 1, 0, 0, 0);
      add(0, '0, 1, C + 32'h1010, 1, RAS_EN ? C + 32'h204 : C + 32'h3000, 2, RAS_EN ? 3'd1 : 3'd0, 0, 0);
      add(1, mk(0, C + 32'h204, 1, C + 32'h1000, 0, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, mk(0, C + 32'h208, 1, C + 32'h1000, 0, 1, 0, 1, 0), 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, '0, 1, C + 32'h200, 1, C + 32'h1000, 1, 0, 0, 0);
      add(0, '0, 1, C + 32'h204, 1, C + 32'h1000, 1, RAS_EN ? 3'd1 : 3'd0, 0, 0);
      add(0, '0, 1, C + 32'h208, 1, C + 32'h1000, 1, RAS_EN ? 3'd2 : 3'd0, 0, 0);
      add(1, mk(1, C + 32'h500, 0, 0, 0, 0, 0, 1, 1), 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, '0, 1, C + 32'h1010, 1, RAS_EN ? C + 32'h204 : C + 32'h3000, 2, RAS_EN ? 3'd1 : 3'd0, 0, 0);
      // same-cycle correction miss drops the speculative push
      add(0, '0, 1, C + 32'h204, 1, C + 32'h1000, 1, 0, 0, 0);
      add(1, mk(1, C + 32'h500, 0, 0, 0, 0, 0, 1, 1), 1, C + 32'h200, 1, C + 32'h1000, 1, RAS_EN ? 3'd1 : 3'd0, 0, 0);
      add(0, '0, 1, C + 32'h1010, 1, RAS_EN ? C + 32'h208 : C + 32'h3000, 2, RAS_EN ? 3'd1 : 3'd0, 0, 0);
      // same-cycle write and read of one index returns the old entry
      add(1, mk(0, C + 32'h700, 1, C + 32'h900, 0, 3, 0, 1, 0), 1, C + 32'h700, 0, C + 32'h704, 0, 0, 0, 0);
      add(0, '0, 1, C + 32'h700, 1, C + 32'h900, 3, 0, 0, 0);

      @(negedge clk);
      check("rst.ready", ready_o, 1'b0);
      check("rst.valid", predict_valid_o, 1'b0);
      check("rst.pred", bpu_predict_o, '0);
      rst = 1'b0;
      n = 0;
      while (!ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("init.cycles", n, 64);

      for (int i = 0; i < nv; i++) begin
         correct_valid_i = vt[i].dc; bpu_correct_i = vt[i].c;
         fetch_valid_i = vt[i].df; fetch_pc_i = vt[i].pc;
         @(negedge clk);
         correct_valid_i = 1'b0; fetch_valid_i = 1'b0;
         check($sformatf("vec%0d.valid", i), predict_valid_o, vt[i].df);
         if (vt[i].df) begin
            check($sformatf("vec%0d.taken", i), bpu_predict_o.taken, vt[i].et);
            check($sformatf("vec%0d.pc", i), bpu_predict_o.predict_pc, vt[i].epc);
            check($sformatf("vec%0d.ttype", i), bpu_predict_o.target_type, vt[i].ett);
            check($sformatf("vec%0d.ras_ptr", i), bpu_predict_o.ras_ptr, vt[i].eras);
            if (vt[i].cl) check($sformatf("vec%0d.lphr", i), bpu_predict_o.lphr, vt[i].el);
         end
      end

      // Reset mid-sweep restarts it; traffic during init is ignored.
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      for (int k = 0; k < 20; k++) @(negedge clk);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      fetch_valid_i = 1'b1; fetch_pc_i = C + 32'h604;
      correct_valid_i = 1'b1; bpu_correct_i = mk(0, C + 32'h604, 1, C + 32'ha00, 0, 3, 0, 1, 0);
      n = 0; bad = 0;
      while (!ready_o && n < 200) begin
         if (predict_valid_o) bad++;
         @(negedge clk);
         n++;
      end
      fetch_valid_i = 1'b0; correct_valid_i = 1'b0;
      check("reinit.cycles", n, 64);
      check("reinit.no_pred", bad, 0);
      fetch_chk("reinit.f604", C + 32'h604, 1'b0, C + 32'h608);
      fetch_chk("reinit.f200", C + 32'h200, 1'b0, C + 32'h204);
      @(negedge clk);
      check("idle.valid", predict_valid_o, 1'b0);

      for (int i = 0; i < 64; i++) begin
         m_v[i] = 0; m_lhr[i] = 0; m_pht[i] = 1; m_tag[i] = 0; m_tgt[i] = 0; m_dir[i] = 0; m_tt[i] = 0;
      end
      for (int i = 0; i < 8; i++) m_ras[i] = '0;
      m_ptr = 0;
      exp_valid = 1'b0; exp_pred = '0;

      for (int it = 0; it < 3000; it++) begin
         fv = ($urandom % 4) != 0;
         st = ($urandom % 4) == 0;
         cv = ($urandom % 3) == 0;
         pc = C | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 2);
         c = mk(($urandom % 4) == 0, C | ($urandom_range(0, 1) << 8) | ($urandom_range(0, 3) << 2),
                1'($urandom), C | ($urandom & 32'h0000_fffc), 1'($urandom), 2'($urandom),
                6'($urandom), 2'($urandom), 3'($urandom));
         fetch_valid_i = fv; fetch_stall_i = st; fetch_pc_i = pc;
         correct_valid_i = cv; bpu_correct_i = c;
         acc = fv && !st;
         p = m_predict(pc);
         if (!st) begin
            exp_valid = fv;
            if (fv) exp_pred = p;
         end
         m_step(cv, c, acc, p, pc);
         @(negedge clk);
         check("rnd.valid", predict_valid_o, exp_valid);
         if (exp_valid) check("rnd.pred", bpu_predict_o, exp_pred);
      end
      fetch_valid_i = 1'b0; fetch_stall_i = 1'b0; correct_valid_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
